// File: rtl/mtm_alu_deserializer_if.sv
// Serial-in / parallel-out bundle between the MTM ALU input pin and its core.
interface mtm_alu_deserializer_if;
  logic        sin;
  logic [31:0] a;
  logic [31:0] b;
  logic [2:0]  op;
  logic        out_valid;
  logic        err_data;
  logic        err_crc;

  modport master (output sin, input a, b, op, out_valid, err_data, err_crc);
  modport slave  (input sin, output a, b, op, out_valid, err_data, err_crc);
endinterface

// File: rtl/mtm_alu_deserializer.sv
// MTM ALU frame receiver: assembles 11-bit serial words into {B, A, OP},
// checks framing and CRC-4, and strobes the result to the ALU core.
module mtm_alu_deserializer (
  input  logic                   clk,
  input  logic                   rst,
  mtm_alu_deserializer_if.slave  bus
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] TYPE   = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] STOP   = 3'd3;
  localparam logic [2:0] RESYNC = 3'd4;

  logic [2:0]  state_q, state_d;
  logic [2:0]  bcnt_q, bcnt_d;
  logic        type_q, type_d;
  logic [7:0]  shreg_q, shreg_d;
  logic [3:0]  wcnt_q, wcnt_d;
  logic [63:0] buf_q, buf_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [2:0]  op_q, op_d;
  logic        vld_q, vld_d;
  logic        errd_q, errd_d;
  logic        errc_q, errc_d;
  logic        abort;
  logic [3:0]  crc;

  // x^4+x+1 over {B, A, 1, OP}, MSB first, zero seed; evaluated while in STOP
  function automatic logic [3:0] crc4(input logic [67:0] msg);
    logic [3:0] c;
    logic       fb;
    c = 4'b0000;
    for (int i = 67; i >= 0; i--) begin
      fb = c[3] ^ msg[i];
      c  = {c[2:0], 1'b0} ^ (fb ? 4'b0011 : 4'b0000);
    end
    return c;
  endfunction

  assign crc = crc4({buf_q, 1'b1, shreg_q[6:4]});

  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q;
    type_d  = type_q;
    shreg_d = shreg_q;
    wcnt_d  = wcnt_q;
    buf_d   = buf_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    vld_d   = 1'b0;
    errd_d  = 1'b0;
    errc_d  = 1'b0;
    abort   = 1'b0;
    case (state_q)
      IDLE:   if (!bus.sin) state_d = TYPE;
      TYPE: begin
        type_d  = bus.sin;
        bcnt_d  = 3'd7;
        state_d = DATA;
      end
      DATA: begin
        shreg_d = {shreg_q[6:0], bus.sin};
        bcnt_d  = bcnt_q - 3'd1;
        if (bcnt_q == 3'd0) state_d = STOP;
      end
      STOP: begin
        if (bus.sin) begin
          state_d = IDLE;
          if (!type_q) begin
            // bytes shift in at the bottom so eight words leave {B, A} in buf
            if (wcnt_q != 4'd8) begin
              buf_d  = {buf_q[55:0], shreg_q};
              wcnt_d = wcnt_q + 4'd1;
            end else begin
              abort = 1'b1;
            end
          end else if (wcnt_q != 4'd8 || shreg_q[7]) begin
            abort = 1'b1;
          end else begin
            vld_d  = 1'b1;
            errc_d = (crc != shreg_q[3:0]);
            b_d    = buf_q[63:32];
            a_d    = buf_q[31:0];
            op_d   = shreg_q[6:4];
            wcnt_d = 4'd0;
          end
        end else begin
          state_d = RESYNC;
          abort   = 1'b1;
        end
      end
      RESYNC: if (bus.sin) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort) begin
      vld_d  = 1'b1;
      errd_d = 1'b1;
      wcnt_d = 4'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      bcnt_q  <= 3'd0;
      type_q  <= 1'b0;
      shreg_q <= 8'd0;
      wcnt_q  <= 4'd0;
      buf_q   <= 64'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      op_q    <= 3'd0;
      vld_q   <= 1'b0;
      errd_q  <= 1'b0;
      errc_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
      type_q  <= type_d;
      shreg_q <= shreg_d;
      wcnt_q  <= wcnt_d;
      buf_q   <= buf_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      vld_q   <= vld_d;
      errd_q  <= errd_d;
      errc_q  <= errc_d;
    end
  end

  assign bus.a         = a_q;
  assign bus.b         = b_q;
  assign bus.op        = op_q;
  assign bus.out_valid = vld_q;
  assign bus.err_data  = errd_q;
  assign bus.err_crc   = errc_q;

endmodule

// File: tb/tb_mtm_alu_deserializer.sv
// Bench for mtm_alu_deserializer: word-level reference model with a queue of
// expected strobes, directed scenarios followed by randomized frames.
module tb_mtm_alu_deserializer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mtm_alu_deserializer_if ifc ();
  mtm_alu_deserializer dut (.clk(clk), .rst(rst), .bus(ifc.slave));

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic        ed;
    logic        ec;
  } exp_t;

  exp_t        exp_q[$];
  logic [7:0]  bq[$];
  logic [31:0] ma, mb;
  logic [2:0]  mop;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // CRC as the remainder of polynomial long division by 10011
  function automatic logic [3:0] crc_ref(input logic [67:0] msg);
    logic [71:0] m;
    m = {msg, 4'b0000};
    for (int i = 71; i >= 4; i--)
      if (m[i]) m[i-:5] = m[i-:5] ^ 5'b10011;
    return m[3:0];
  endfunction

  task automatic push_exp(input int c, input logic ed, input logic ec);
    exp_t e;
    e.cyc = c; e.a = ma; e.b = mb; e.op = mop; e.ed = ed; e.ec = ec;
    exp_q.push_back(e);
  endtask

  task automatic model_word(input bit ty, input logic [7:0] d, input bit stop, input int c);
    if (!stop) begin
      bq.delete(); push_exp(c, 1'b1, 1'b0);
    end else if (!ty) begin
      if (bq.size() < 8) bq.push_back(d);
      else begin bq.delete(); push_exp(c, 1'b1, 1'b0); end
    end else if (bq.size() != 8 || d[7]) begin
      bq.delete(); push_exp(c, 1'b1, 1'b0);
    end else begin
      mb  = {bq[0], bq[1], bq[2], bq[3]};
      ma  = {bq[4], bq[5], bq[6], bq[7]};
      mop = d[6:4];
      push_exp(c, 1'b0, crc_ref({mb, ma, 1'b1, mop}) != d[3:0]);
      bq.delete();
    end
  endtask

  task automatic send_word(input bit ty, input logic [7:0] d, input bit stop, input int gap);
    logic [10:0] w;
    int          sc;
    w = {1'b0, ty, d, stop};
    for (int i = 10; i >= 0; i--) begin
      @(negedge clk);
      ifc.sin = w[i];
    end
    sc = cyc;
    model_word(ty, d, stop, sc + 1);
    repeat (gap) begin
      @(negedge clk);
      ifc.sin = 1'b1;
    end
  endtask

  task automatic send_frame(input logic [31:0] b, input logic [31:0] a, input logic [2:0] op,
                            input bit badcrc, input int maxgap);
    logic [63:0] fr;
    logic [3:0]  c;
    fr = {b, a};
    for (int i = 0; i < 8; i++)
      send_word(1'b0, fr[63-8*i -: 8], 1'b1, $urandom_range(maxgap, 0));
    c = crc_ref({b, a, 1'b1, op});
    if (badcrc) c = c ^ 4'($urandom_range(15, 1));
    send_word(1'b1, {1'b0, op, c}, 1'b1, $urandom_range(maxgap, 0));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_a"},  ifc.a, 32'd0);
    chk({tag, "_b"},  ifc.b, 32'd0);
    chk({tag, "_op"}, ifc.op, 3'd0);
    chk({tag, "_flags"}, {ifc.out_valid, ifc.err_data, ifc.err_crc}, 3'b000);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst === 1'b1) begin
      if (ifc.out_valid) begin
        if (exp_q.size() == 0) chk("spurious_strobe", ifc.out_valid, 1'b0);
        else begin
          e = exp_q.pop_front();
          chk("strobe_cycle", cyc, e.cyc);
          chk("a", ifc.a, e.a);
          chk("b", ifc.b, e.b);
          chk("op", ifc.op, e.op);
          chk("err_data", ifc.err_data, e.ed);
          chk("err_crc", ifc.err_crc, e.ec);
        end
      end else begin
        chk("flags_idle", {ifc.err_data, ifc.err_crc}, 2'b00);
        if (exp_q.size() != 0 && cyc > exp_q[0].cyc) begin
          chk("missed_strobe", ifc.out_valid, 1'b1);
          void'(exp_q.pop_front());
        end
      end
    end
  end

  logic [7:0]  ord[8];
  logic [31:0] rb, ra;
  logic [2:0]  rop;
  int          k, n;

  initial begin
    rst = 1'b0; ifc.sin = 1'b1;
    ma = '0; mb = '0; mop = '0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst = 1'b1;
    repeat (3) @(negedge clk);

    // zero operands, OP=000, CRC 1011
    for (int i = 0; i < 8; i++) send_word(1'b0, 8'h00, 1'b1, 0);
    send_word(1'b1, 8'b0000_1011, 1'b1, 0);
    // OP=001 good (CRC 1000), then same frame with CRC 1011
    for (int i = 0; i < 8; i++) send_word(1'b0, 8'h00, 1'b1, 0);
    send_word(1'b1, 8'b0001_1000, 1'b1, 2);
    for (int i = 0; i < 8; i++) send_word(1'b0, 8'h00, 1'b1, 0);
    send_word(1'b1, 8'b0001_1011, 1'b1, 3);

    // operand ordering with ragged gaps
    ord = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
    for (int i = 0; i < 8; i++) send_word(1'b0, ord[i], 1'b1, $urandom_range(5, 0));
    send_word(1'b1, {1'b0, 3'b101, crc_ref({64'h12345678_9ABCDEF0, 1'b1, 3'b101})}, 1'b1, 3);
    chk("order_b", ifc.b, 32'h12345678);
    chk("order_a", ifc.a, 32'h9ABCDEF0);

    // command after four data words, then a good frame
    for (int i = 0; i < 4; i++) send_word(1'b0, 8'($urandom), 1'b1, 1);
    send_word(1'b1, 8'h05, 1'b1, 2);
    send_frame(32'hCAFEF00D, 32'h01234567, 3'b110, 1'b0, 2);
    // ninth data word
    for (int i = 0; i < 9; i++) send_word(1'b0, 8'($urandom), 1'b1, 0);
    repeat (3) @(negedge clk);

    // stop-bit error in word 3, line stuck low, then recovery
    send_word(1'b0, 8'hA5, 1'b1, 0);
    send_word(1'b0, 8'h5A, 1'b1, 0);
    send_word(1'b0, 8'h3C, 1'b0, 0);
    repeat (20) begin @(negedge clk); ifc.sin = 1'b0; end
    @(negedge clk); ifc.sin = 1'b1;
    send_frame(32'h11112222, 32'h33334444, 3'b011, 1'b0, 1);

    // reset in the middle of word 6
    for (int i = 0; i < 5; i++) send_word(1'b0, 8'hEE, 1'b1, 0);
    @(negedge clk); ifc.sin = 1'b0;
    @(negedge clk); ifc.sin = 1'b0;
    @(negedge clk); ifc.sin = 1'b1;
    @(negedge clk); ifc.sin = 1'b0;
    @(negedge clk); rst = 1'b0; ifc.sin = 1'b1;
    @(negedge clk); rst = 1'b1;
    chk_zero("midreset");
    bq.delete(); ma = '0; mb = '0; mop = '0;
    repeat (2) @(negedge clk);
    send_frame(32'h0BADBEEF, 32'h76543210, 3'b010, 1'b0, 0);

    for (int it = 0; it < 40; it++) begin
      k = $urandom_range(5, 0);
      rb = $urandom; ra = $urandom; rop = 3'($urandom);
      case (k)
        0, 1: send_frame(rb, ra, rop, $urandom_range(3, 0) == 0, 3);
        2: begin
          n = $urandom_range(7, 0);
          for (int j = 0; j < n; j++) send_word(1'b0, 8'($urandom), 1'b1, $urandom_range(2, 0));
          send_word(1'b1, {1'b0, rop, 4'($urandom)}, 1'b1, 1);
        end
        3: begin
          n = $urandom_range(8, 0);
          for (int j = 0; j < n; j++) send_word(1'b0, 8'($urandom), 1'b1, 0);
          send_word(1'b0, 8'($urandom), 1'b0, 0);
          repeat ($urandom_range(4, 0)) begin @(negedge clk); ifc.sin = 1'b0; end
          @(negedge clk); ifc.sin = 1'b1;
        end
        4: begin
          for (int j = 0; j < 8; j++) send_word(1'b0, 8'($urandom), 1'b1, 0);
          send_word(1'b1, {1'b1, rop, 4'($urandom)}, 1'b1, 1);
        end
        default: send_frame(rb, ra, rop, 1'b0, 0);
      endcase
    end

    repeat (20) @(negedge clk);
    chk("pending_strobes", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mtm_alu_deserializer.md
# mtm_alu_deserializer

Serial-input frame receiver for the MTM ALU. It samples the one-bit `sin` line once per clock and assembles 11-bit words into a complete operation frame: 8 data words carrying operands B and A, then 1 command word. It checks framing and CRC-4, then presents `a`, `b` and `op` with a one-cycle strobe to the ALU core. It is the input-side counterpart of the frame serializer that drives `sout`.

## Interface
Parameters: none.

Ports:
- `clk`  in  1  clock; all logic on posedge
- `rst`  in  1  reset, synchronous, active-low; clock `clk`
- `sin`  in  1  serial input; idle high; already synchronized at top level
- `a`  out  32  operand A from the last accepted frame
- `b`  out  32  operand B from the last accepted frame
- `op`  out  3  operation code from the last accepted frame
- `out_valid`  out  1  one-cycle strobe; frame completed or aborted
- `err_data`  out  1  framing error; meaningful only with `out_valid`
- `err_crc`  out  1  CRC mismatch; meaningful only with `out_valid`

## Operation
- **Word format**, sampled one bit per clock:
  - start bit 0
  - type bit (0 = data, 1 = command)
  - 8 payload bits, MSB first
  - stop bit 1
- **Frame order**:
  - data words 1..4 carry B[31:24], B[23:16], B[15:8], B[7:0]
  - data words 5..8 carry A[31:24] .. A[7:0]
  - command word payload: bit7 = 0, bits6:4 = OP, bits3:0 = CRC
- **Word gaps**: any number of idle-high cycles is allowed between words. There is no timeout.
- **FSM states**: IDLE, TYPE, DATA, STOP, RESYNC.
  - IDLE: `sin`=0 -> TYPE.
  - TYPE: latch the type bit -> DATA, with the bit counter set to 7.
  - DATA: shift in a bit and decrement the counter; after the 8th bit -> STOP.
  - STOP, `sin`=1: the word is complete; process it (rules below); -> IDLE.
  - STOP, `sin`=0: abort with `err_data`; -> RESYNC.
  - RESYNC: wait for `sin`=1 -> IDLE. This stops a stuck-low line from being read as a new start bit.
- **Word counter** wcnt 0..8, reset to 0 on every frame end or abort.
- **Completed data word**:
  - wcnt<8: store the byte and increment wcnt.
  - wcnt==8 (ninth data word): abort with `err_data`.
- **Completed command word**:
  - wcnt!=8 or payload bit7=1: abort with `err_data`.
  - Otherwise compute the CRC. The message is the 68-bit {B, A, 1'b1, OP}, MSB first; polynomial x^4+x+1; initial value 4'b0000.
  - Mismatch with the received CRC: `err_crc`=1. Match: `err_crc`=0.
  - In both cases `a`, `b` and `op` update to the frame contents.
- **On abort**:
  - `a`, `b` and `op` hold their previous values.
  - `err_crc` is 0.
  - `err_data`=1 takes priority; at most one error flag is set per strobe.
- **Reset**, at any time including mid-frame:
  - state IDLE, wcnt=0, byte buffer cleared.
  - `a`=0, `b`=0, `op`=0.
  - `out_valid`=0, `err_data`=0, `err_crc`=0.

## Timing
- **Word bit positions**: start bit sampled at cycle t, type at t+1, payload at t+2..t+9, stop at t+10.
- **Strobe**: `out_valid` is high in cycle t+11 only, with `a`, `b`, `op` and the error flags registered and stable from t+11.
- **Held values**: `a`, `b` and `op` hold until the next accepted command word. The error flags return to 0 when `out_valid` deasserts.
- **Back-to-back words**: the next start bit may be sampled at t+11. The receiver must accept it, with no dead cycle.
- **Frame length**: the minimum full frame is 99 cycles from the first start bit to the last stop bit. The strobe comes 1 cycle later.
- **CRC timing**: the CRC is either computed serially while bits arrive or combinationally at STOP. Either way, the strobe latency stays at t+11.
- **No backpressure**: the consumer must take the outputs in the `out_valid` cycle.

## Test plan
- **Good frame, CRC match**: after reset, send a frame with B=0, A=0, OP=000, CRC=4'b1011. Expect one `out_valid` pulse 1 cycle after the final stop bit, with `a`=0, `b`=0, `op`=000, `err_data`=0, `err_crc`=0.
- **Good frame, then bad CRC**: send a frame with B=0, A=0, OP=001, CRC=4'b1000 and expect `op`=001 with no error. Then send the same frame with CRC=4'b1011. Expect `err_crc`=1, `err_data`=0, and `op`=001 updated.
- **Operand ordering**: send data bytes 8'h12, 34, 56, 78, 9A, BC, DE, F0 with 0..5 idle cycles between words, followed by a command word whose CRC is taken from the golden model. Expect `b`=32'h12345678 and `a`=32'h9ABCDEF0.
- **Framing errors**:
  - A command word after only 4 data words: expect `err_data` strobe, `a`/`b` unchanged, next frame received correctly.
  - A ninth data word: expect `err_data`.
- **Stop-bit error and resync**: drive the stop bit to 0 in word 3 and hold `sin` low for 20 cycles. Expect exactly one `err_data` strobe and no further strobes. After `sin` returns high, a following good frame is accepted.
- **Reset mid-frame**: assert `rst`=0 for 1 cycle in the middle of word 6. Expect all outputs 0. The next full frame must be decoded correctly, with no leftover bytes from the interrupted frame.
